// File: rtl/snn_bus_pkg.sv
// Shared types and address-field positions for the two-core SNN bus initiator.
package snn_bus_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OFFSET_W   = 16;
    localparam int unsigned CORE_BIT   = 16;
    localparam int unsigned REGION_LSB = 17;
    localparam int unsigned REGION_MSB = 18;

    typedef enum logic [1:0] {
        SPIKE_IN    = 2'b00,
        PARAM_IN    = 2'b01,
        SPIKE_OUT   = 2'b10,
        ENABLE_CALC = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RSP    = 2'd3
    } state_e;

    // Latched command payload
    typedef struct packed {
        logic                core;
        logic                bcast;
        region_e             region;
        logic [OFFSET_W-1:0] offset;
        logic [DATA_W-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/snn_bus_initiator_if.sv
// Command/response and bus handshake bundle; master is the initiator's view.
interface snn_bus_initiator_if;
    import snn_bus_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_core_i;
    logic                cmd_bcast_i;
    logic [1:0]          cmd_region_i;
    logic [OFFSET_W-1:0] cmd_offset_i;
    logic [DATA_W-1:0]   cmd_wdata_i;
    logic                rsp_valid_o;
    logic                rsp_err_o;
    logic [DATA_W-1:0]   rsp_data_o;
    logic                bus_req_o;
    logic                bus_we_o;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_wdata_o;
    logic                bus_gnt_i;
    logic                bus_rvalid_i;
    logic [DATA_W-1:0]   bus_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_core_i, cmd_bcast_i, cmd_region_i, cmd_offset_i, cmd_wdata_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_core_i, cmd_bcast_i, cmd_region_i, cmd_offset_i, cmd_wdata_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

endinterface

// File: rtl/snn_addr_encode.sv
// Core/region/offset to 32-bit bus address; inverse of the decoder's bit mapping.
module snn_addr_encode
    import snn_bus_pkg::*;
(
    input  logic                core_i,
    input  region_e             region_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic [ADDR_W-1:0]   addr_o
);

    always_comb begin
        addr_o                        = '0;
        addr_o[OFFSET_W-1:0]          = offset_i;
        addr_o[CORE_BIT]              = core_i;
        addr_o[REGION_MSB:REGION_LSB] = region_i;
    end

endmodule

// File: rtl/snn_bus_initiator.sv
// Host-side initiator: turns commands into request/grant bus beats (with
// optional two-core broadcast) and returns exactly one response per command.
module snn_bus_initiator
    import snn_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    snn_bus_initiator_if.master bus_if
);

    localparam int unsigned         CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_err_set;
    logic [DATA_W-1:0]   rsp_data_set;
    logic [ADDR_W-1:0]   enc_addr;

    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    snn_addr_encode u_addr_encode (
        .core_i   (cmd_d.core),
        .region_i (cmd_d.region),
        .offset_i (cmd_d.offset),
        .addr_o   (enc_addr)
    );

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next state, command latch and wait counter
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_d        = cnt_q;
        rsp_err_set  = 1'b0;
        rsp_data_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.cmd_valid_i) begin
                    cmd_d.core   = bus_if.cmd_core_i & ~bus_if.cmd_bcast_i;
                    cmd_d.bcast  = bus_if.cmd_bcast_i;
                    cmd_d.region = region_e'(bus_if.cmd_region_i);
                    cmd_d.offset = bus_if.cmd_offset_i;
                    cmd_d.wdata  = bus_if.cmd_wdata_i;
                    cnt_d        = '0;
                    // A broadcast read has no meaning; reject without bus traffic
                    if (bus_if.cmd_bcast_i && (region_e'(bus_if.cmd_region_i) == SPIKE_OUT)) begin
                        state_d     = ST_RSP;
                        rsp_err_set = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus_if.bus_gnt_i) begin
                    cnt_d = '0;
                    if (cmd_q.region == SPIKE_OUT) begin
                        state_d = ST_WAIT_R;
                    end else if (cmd_q.bcast && !cmd_q.core) begin
                        cmd_d.core = 1'b1;
                    end else begin
                        state_d = ST_RSP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RSP;
                    rsp_err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_R: begin
                if (bus_if.bus_rvalid_i) begin
                    state_d      = ST_RSP;
                    rsp_data_set = bus_if.bus_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RSP;
                    rsp_err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; bus fields hold outside REQ
    always_comb begin
        bus_req_d   = (state_d == ST_REQ);
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        if (state_d == ST_REQ) begin
            bus_addr_d  = enc_addr;
            bus_we_d    = (cmd_d.region != SPIKE_OUT);
            bus_wdata_d = cmd_d.wdata;
        end
        rsp_valid_d = (state_d == ST_RSP);
        rsp_err_d   = rsp_err_set;
        rsp_data_d  = rsp_data_set;
    end

    assign bus_if.cmd_ready_o = (state_q == ST_IDLE);
    assign bus_if.rsp_valid_o = rsp_valid_q;
    assign bus_if.rsp_err_o   = rsp_err_q;
    assign bus_if.rsp_data_o  = rsp_data_q;
    assign bus_if.bus_req_o   = bus_req_q;
    assign bus_if.bus_we_o    = bus_we_q;
    assign bus_if.bus_addr_o  = bus_addr_q;
    assign bus_if.bus_wdata_o = bus_wdata_q;

endmodule

// File: doc/snn_bus_initiator.md
# snn_bus_initiator

Host-side bus initiator for the two-core SNN memory map. It accepts high-level commands (core, region, offset, data) and encodes them into 32-bit bus addresses. It runs the request/grant and read-response handshakes, and returns one response per command. It sits between the host/command source and the address decoder that fans the bus out to core 0/1 spike-in, parameter, spike-out and calc-enable regions.

## Interface
- `TIMEOUT`, default 255: max consecutive wait cycles in REQ or WAIT_R before an error response (≥1).
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i & cmd_ready_o`.
- `cmd_core_i`  in  1  target core (0/1).
- `cmd_bcast_i`  in  1  issue to core 0 then core 1 (writes only).
- `cmd_region_i`  in  2  00 spike_in (wr), 01 param (wr), 10 spike_out (rd), 11 enable_calc (wr).
- `cmd_offset_i`  in  16  word offset within region.
- `cmd_wdata_i`  in  32  write data.
- `rsp_valid_o`  out  1  one-cycle response strobe, no backpressure.
- `rsp_err_o`  out  1  response is an error (valid with `rsp_valid_o`).
- `rsp_data_o`  out  32  read data (0 for writes and errors).
- `bus_req_o`  out  1  bus request.
- `bus_we_o`  out  1  1 = write.
- `bus_addr_o`  out  32  encoded address.
- `bus_wdata_o`  out  32  write data.
- `bus_gnt_i`  in  1  request accepted this cycle.
- `bus_rvalid_i`  in  1  read data valid.
- `bus_rdata_i`  in  32  read data.

## Operation
- **Address encoding:** `addr[31:19]=0`, `addr[18:17]=region`, `addr[16]=core`, `addr[15:0]=offset`.
- **`bus_we_o`:** 0 only for region 10.
- **States:** IDLE, REQ, WAIT_R, RSP.
- **IDLE:**
  - `cmd_ready_o=1`.
  - On accept, latch all cmd fields and go to REQ.
  - If bcast, latch core as 0.
  - Exception: a bcast with region 10 goes directly to RSP with err=1 and issues no bus traffic.
- **REQ:**
  - `bus_req_o=1`; addr, we and wdata are held stable until grant.
  - On `bus_gnt_i`, one of:
    - Read: go to WAIT_R.
    - Bcast write with latched core 0: set core to 1 and stay in REQ. The next beat starts the following cycle and the timeout counter is cleared.
    - Otherwise: go to RSP with err=0.
- **WAIT_R:**
  - `bus_req_o=0`.
  - On `bus_rvalid_i`, capture `bus_rdata_i` and go to RSP with err=0.
  - `bus_rvalid_i` is ignored in every other state.
- **Timeout:**
  - The wait counter clears on entry to REQ/WAIT_R and increments each cycle without the awaited event.
  - If the awaited event has not arrived by the TIMEOUT-th consecutive cycle, leave at that cycle's edge to RSP with err=1, rsp_data=0, `bus_req_o` dropped.
  - An event in that same cycle wins over the timeout.
  - A bcast timeout on the core-0 beat aborts the core-1 beat.
- **RSP:** `rsp_valid_o=1` for exactly one cycle, then IDLE.
- **Reset mid-operation:** any outstanding request is abandoned, no response is produced, and a late `bus_rvalid_i` after reset is ignored.

## Timing
- **Reset values:** state IDLE; `cmd_ready_o=1`; `rsp_valid_o=0`, `rsp_err_o=0`, `rsp_data_o=0`; `bus_req_o=0`, `bus_we_o=0`, `bus_addr_o=0`, `bus_wdata_o=0`. Timeout counter 0.
- **Registered outputs:** all outputs are registered, except `cmd_ready_o`, which is decoded from state.
- **Command accepted at edge N:**
  - `bus_req_o` rises in cycle N+1.
  - Write with gnt in cycle N+1: `rsp_valid_o` in cycle N+2.
  - Read with gnt in N+1 and rvalid in N+2: `rsp_valid_o` in N+3.
  - Bcast write with immediate grants: beats in N+1 and N+2, response in N+3.
- **Throughput:** next command accepted earliest in the cycle after RSP (back in IDLE).
- **Bus outputs when not requesting:** `bus_addr_o`, `bus_we_o` and `bus_wdata_o` hold their last value.

## Structure
- **Package `snn_bus_pkg`:**
  - region enum (SPIKE_IN, PARAM_IN, SPIKE_OUT, ENABLE_CALC);
  - address field positions (`CORE_BIT=16`, `REGION_LSB=17`, `REGION_MSB=18`, `OFFSET_W=16`);
  - state enum.
- **Sub-module `snn_addr_encode`:** combinational core/region/offset to 32-bit address. It is the exact inverse of the decoder bit mapping.

## Test plan
- Write param, core 1, offset 0x0004, data 0xDEADBEEF, immediate gnt -> one beat, addr 0x0003_0004, we=1, rsp err=0 at N+2.
- Read spike_out, core 0, offset 0x0010, gnt delayed 3 cycles, rvalid 2 cycles later with 0x12345678 -> addr 0x0004_0010, we=0, req held stable throughout, rsp_data 0x12345678.
- Bcast enable_calc, wdata 1 -> beats at 0x0006_0000 then 0x0007_0000, a single rsp with err=0; `cmd_ready_o` low throughout.
- TIMEOUT=4, write with gnt never asserted -> req high for 4 cycles, then rsp err=1, req low; gnt arriving on the 4th cycle instead -> err=0.
- Bcast with region 10 -> no `bus_req_o`, rsp err=1 in the cycle after accept.
- `rst_ni` low during WAIT_R, then rvalid after release -> no rsp, all outputs at reset values, `cmd_ready_o=1`.
